// File: rtl/rs255_pkg.sv
// rtl/rs255_pkg.sv - shared constants, generator coefficients and FSM state type for the RS(255,247) encoder
package rs255_pkg;

    localparam logic [8:0] GF_POLY = 9'h11d;
    localparam int RS_N    = 255;
    localparam int RS_K    = 247;
    localparam int RS_NPAR = 8;

    // g(x) = x^8 + sum GEN_COEF[i] x^i, roots alpha^0 .. alpha^7
    localparam logic [7:0] GEN_COEF [0:7] = '{
        8'h18, 8'hc8, 8'had, 8'hef, 8'h36, 8'h51, 8'h0b, 8'hff
    };

    typedef enum logic {
        MSG = 1'b0,
        PAR = 1'b1
    } state_t;

endpackage

// File: rtl/rs255_247_enc_if.sv
// rtl/rs255_247_enc_if.sv - message-in / codeword-out handshake bundle of the RS(255,247) encoder
interface rs255_247_enc_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/rs255_247_enc_gf256mul.sv
// rtl/rs255_247_enc_gf256mul.sv - combinational GF(256) multiplier modulo x^8+x^4+x^3+x^2+1
module gf256mul
    import rs255_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [14:0] prod;

    // carry-less product, then fold bits 14..8 back with the field polynomial
    always_comb begin
        prod = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                prod = prod ^ (15'(a) << i);
            end
        end
        for (int k = 14; k >= 8; k--) begin
            if (prod[k]) begin
                prod = prod ^ (15'(GF_POLY) << (k - 8));
            end
        end
        p = prod[7:0];
    end

endmodule

// File: rtl/rs255_247_enc.sv
// rtl/rs255_247_enc.sv - systematic RS(255,247) encoder; RS_ENC_SHORTEN_EN enables in_last-terminated shortened blocks
module rs255_247_enc
    import rs255_pkg::*;
#(
    parameter int GEN_FCR = 0
)(
    input  logic             clk,
    input  logic             rst,
    rs255_247_enc_if.slave   bus
);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  r [0:7];
    logic [7:0]  prod [0:7];
    logic [7:0]  fb;
    logic [7:0]  msg_cnt;
    logic [2:0]  par_cnt;
    logic        out_valid_q;
    logic [7:0]  out_data_q;
    logic        out_last_q;
    logic        load_ok;
    logic        msg_acc;
    logic        par_ld;
    logic        block_end;
    logic        unused_cfg;

    assign load_ok  = !out_valid_q || bus.out_ready;
    assign msg_acc  = bus.in_valid && bus.in_ready;
    assign par_ld   = (state == PAR) && load_ok;
    assign fb       = bus.in_data ^ r[7];

    assign bus.in_ready  = (state == MSG) && load_ok;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

`ifdef RS_ENC_SHORTEN_EN
    assign block_end  = msg_acc && (bus.in_last || (msg_cnt == 8'(RS_K - 1)));
    assign unused_cfg = (GEN_FCR != 0);
`else
    assign block_end  = msg_acc && (msg_cnt == 8'(RS_K - 1));
    assign unused_cfg = (GEN_FCR != 0) ^ bus.in_last;
`endif

    // feedback times each generator coefficient; constant operand folds away
    for (genvar i = 0; i < RS_NPAR; i++) begin : g_mul
        gf256mul u_mul (
            .a (GEN_COEF[i]),
            .b (fb),
            .p (prod[i])
        );
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MSG;
        end else begin
            state <= state_nxt;
        end
    end

    // next state: leave MSG on the block-ending accept, leave PAR after loading p0
    always_comb begin
        state_nxt = state;
        case (state)
            MSG: if (block_end) state_nxt = PAR;
            PAR: if (par_ld && (par_cnt == 3'd7)) state_nxt = MSG;
            default: state_nxt = MSG;
        endcase
    end

    // parity LFSR: divide while accepting message, shift out toward r[7] during parity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_NPAR; i++) begin
                r[i] <= '0;
            end
        end else if (msg_acc) begin
            r[0] <= prod[0];
            for (int i = 1; i < RS_NPAR; i++) begin
                r[i] <= r[i-1] ^ prod[i];
            end
        end else if (par_ld) begin
            r[0] <= '0;
            for (int i = 1; i < RS_NPAR; i++) begin
                r[i] <= r[i-1];
            end
        end
    end

    // message and parity symbol counters; par_cnt wraps 7 -> 0 on its own
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_cnt <= '0;
            par_cnt <= '0;
        end else begin
            if (msg_acc) begin
                msg_cnt <= block_end ? 8'd0 : msg_cnt + 8'd1;
            end
            if (par_ld) begin
                par_cnt <= par_cnt + 3'd1;
            end
        end
    end

    // output register: message passes straight through, parity drains from r[7]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (msg_acc) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.in_data;
            out_last_q  <= 1'b0;
        end else if (par_ld) begin
            out_valid_q <= 1'b1;
            out_data_q  <= r[7];
            out_last_q  <= (par_cnt == 3'd7);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

endmodule
